rr_arbiter_burst: RTL and testbench
===================================

Name: rr_arbiter_burst

Overview:
- Parametrised round-robin arbiter; next generation of the team's 4-requester round-robin arbiter.
- Generalises requester count; grants are registered and held as bursts.
- An owner keeps the grant while its request stays high, up to a programmable burst limit, then is pre-empted.
- Sits in front of a shared resource (bus, memory port); drives a one-hot grant, an index and a valid flag.

Parameters:
- N, 4, number of requesters (N >= 2).
- MAX_BURST, 4, maximum consecutive cycles one owner holds the grant (>= 1).
- IDX_W, $clog2(N), width of grant_idx.
- CNT_W, $clog2(MAX_BURST)+1, width of internal burst counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset. The design has one clock; reset is synchronous and active-low.
- req  in  N  level requests, one bit per requester.
- grant  out  N  registered one-hot grant, or all zero.
- grant_valid  out  1  high when grant is non-zero.
- grant_idx  out  IDX_W  binary index of the owner; 0 when grant_valid=0.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - grant=0, grant_valid=0, grant_idx=0.
  - Priority pointer ptr=0, burst_cnt=0, state=IDLE.
  - Applies mid-burst too; the grant drops at that edge.
- State IDLE:
  - At an edge with |req=1: select the first set bit at or after ptr, searching circularly upward.
  - Register the grant, set burst_cnt=0, go to BUSY.
  - With |req=0: stay in IDLE, outputs zero.
- Latency: a req bit first sampled high at edge k produces grant visible after edge k, i.e. one cycle of latency.
- State BUSY, owner o, checked at each edge:
  - Release when req[o]=0 (voluntary) or burst_cnt=MAX_BURST-1 (pre-emption). Otherwise burst_cnt++ and the grant is held.
  - On release: ptr=(o+1) mod N, then re-arbitrate at the same edge with the new ptr. There is no idle bubble.
  - On pre-emption, o is lowest priority. If o is the only requester it is re-granted, with burst_cnt reset to 0.
  - If no requests remain after release: grant=0, go to IDLE.
- ptr changes only on release. It wraps from N-1 to 0.
- Requests from non-owners never shorten a burst; only the owner's req or the limit ends it.
- grant is always one-hot or zero. grant_idx and grant_valid are registered in the same cycle as grant.
- MAX_BURST=1: the grant rotates every cycle among active requesters (plain round robin).
- A req bit that rises and falls between edges is not seen.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds input port lock (width N) after req.
  - While lock[o]=1 and req[o]=1, the burst limit is ignored and burst_cnt saturates at MAX_BURST-1.
  - Release happens only when req[o] drops or lock[o] drops at or after the limit.
- Undefined: the lock port is absent and behaviour is exactly as above.

Decomposition:
- Package arb_pkg: state encoding constants (ARB_IDLE=1'b0, ARB_BUSY=1'b1) and a clog2 helper function.
- One sub-module, rr_pick: combinational rotating-priority encoder.
  - Inputs: req[N], ptr[IDX_W].
  - Outputs: onehot[N], idx[IDX_W], any.
  - Implemented with a double-width mask or priority trick.
- Top level holds the FSM, the pointer, the burst counter and the output registers.

Test Plan (N=4, MAX_BURST=4 unless stated):
- Reset: rst_n=0 for 2 edges with req=1111 -> grant=0000, grant_valid=0, grant_idx=0. First edge after release -> grant=0001.
- Single requester: req=1000 held 10 cycles -> grant=1000 one edge later. It stays continuously 1000 across pre-emptions (re-granted), grant_idx=3.
- Full contention: req=1111 held -> grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 (pointer wrap).
- Early release: owner 0010 with req=0110 drops bit1 after 2 cycles -> grant=0100 at the next edge with no bubble. Then req=0000 -> grant=0000, IDLE.
- MAX_BURST=1 instance, req=1011 held -> grants 0001, 0010, 1000, 0001 on consecutive cycles.
- Reset mid-burst: owner 0100 in cycle 2 of a burst, rst_n=0 for 1 edge -> grant=0000. Restart with req=1100 gives 0100 (ptr reset to 0).
- With ARB_LOCK_EN: lock=0001, req=0011 held -> grant=0001 for 8+ cycles. Drop lock -> 0010 at the next edge.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_pkg : shared FSM encoding and elaboration helpers for the        |
// |           rr_arbiter_burst block.                                    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Ceiling log2 usable in parameter defaults; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : combinational rotating-priority encoder. Returns the first |
// |           set request at or after ptr_i, searching circularly up.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  localparam logic [IDX_W:0] C_N = (IDX_W+1)'(N);

  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic             w_found;
  logic [IDX_W:0]   w_sum;

  // Doubling the vector turns the circular search into a plain shift.
  assign w_dbl = {req_i, req_i};
  assign w_rot = N'(w_dbl >> ptr_i);

  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_off   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, ptr_i} + {1'b0, w_off};
    if (w_sum >= C_N) begin
      w_sum = w_sum - C_N;
    end
  end

  assign idx_o = w_found ? w_sum[IDX_W-1:0] : '0;
  assign any_o = w_found;

  always_comb begin
    onehot_o = '0;
    for (int j = 0; j < N; j++) begin
      if (w_found && (idx_o == IDX_W'(j))) begin
        onehot_o[j] = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/rr_arbiter_burst.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter_burst : N-way round-robin arbiter with registered grants  |
// |   held as bursts of up to MAX_BURST cycles. Define ARB_LOCK_EN to    |
// |   add a per-requester lock input that suspends the burst limit.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rr_arbiter_burst
  import arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 4,
  parameter int IDX_W     = clog2(N),
  parameter int CNT_W     = clog2(MAX_BURST) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]     lock,
`endif
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(N - 1);

  arb_state_e       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     grant_q;
  logic             valid_q;
  logic [IDX_W-1:0] idx_q;

  logic             w_owner_req;
  logic             w_at_limit;
  logic             w_release;
  logic [IDX_W-1:0] w_ptr_d;
  logic [IDX_W-1:0] w_pick_ptr;
  logic [N-1:0]     w_pick_onehot;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;

  assign w_owner_req = req[idx_q];
  assign w_at_limit  = (cnt_q == C_CNT_LAST);

`ifdef ARB_LOCK_EN
  assign w_release = !w_owner_req || (w_at_limit && !lock[idx_q]);
`else
  assign w_release = !w_owner_req || w_at_limit;
`endif

  assign w_ptr_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;

  // On release the search already starts just past the owner, making it
  // lowest priority while still allowing a sole requester to be re-granted.
  assign w_pick_ptr = ((state_q == ARB_BUSY) && w_release) ? w_ptr_d : ptr_q;

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (w_pick_ptr),
    .onehot_o (w_pick_onehot),
    .idx_o    (w_pick_idx),
    .any_o    (w_pick_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (w_pick_any) begin
            grant_q <= w_pick_onehot;
            valid_q <= 1'b1;
            idx_q   <= w_pick_idx;
            cnt_q   <= '0;
            state_q <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (w_release) begin
            ptr_q <= w_ptr_d;
            cnt_q <= '0;
            if (w_pick_any) begin
              grant_q <= w_pick_onehot;
              valid_q <= 1'b1;
              idx_q   <= w_pick_idx;
            end else begin
              grant_q <= '0;
              valid_q <= 1'b0;
              idx_q   <= '0;
              state_q <= ARB_IDLE;
            end
          end else if (!w_at_limit) begin
            // Saturating hold: only a locked owner can sit at the limit.
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          grant_q <= '0;
          valid_q <= 1'b0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;

endmodule : rr_arbiter_burst
`default_nettype wire

// File: tb/tb_rr_arbiter_burst.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rr_arbiter_burst : directed + random bench for two arbiter        |
// |   instances (MAX_BURST=4 and MAX_BURST=1) against a behavioural model.|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_rr_arbiter_burst;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] lock;

  logic [N-1:0] g4, g1;
  logic         v4, v1;
  logic [1:0]   i4, i1;

  int errors = 0;
  int checks = 0;

  // Model state: owner (-1 = none), cycles held so far, priority pointer.
  int own4 = -1, held4 = 0, ptr4 = 0;
  int own1 = -1, held1 = 0, ptr1 = 0;

  always #5 clk = ~clk;

  rr_arbiter_burst #(.N(N), .MAX_BURST(4)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
`ifdef ARB_LOCK_EN
    .lock        (lock),
`endif
    .grant       (g4),
    .grant_valid (v4),
    .grant_idx   (i4)
  );

  rr_arbiter_burst #(.N(N), .MAX_BURST(1)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
`ifdef ARB_LOCK_EN
    .lock        (lock),
`endif
    .grant       (g1),
    .grant_valid (v1),
    .grant_idx   (i1)
  );

  task automatic model_step(input int maxb, inout int own, inout int held, inout int ptr);
    bit rel;
    bit lk;
    bit found;
    if (!rst_n) begin
      own = -1; held = 0; ptr = 0;
    end else begin
      rel = 1'b0;
      if (own >= 0) begin
        lk = 1'b0;
`ifdef ARB_LOCK_EN
        lk = lock[own];
`endif
        rel = !req[own] || (held >= maxb && !lk);
        if (rel) ptr = (own + 1) % N;
        else     held = held + 1;
      end
      if (own < 0 || rel) begin
        own = -1; found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && req[(ptr + k) % N]) begin
            found = 1'b1;
            own = (ptr + k) % N;
          end
        end
        held = 1;
      end
    end
  endtask

  task automatic check_dut(input string tag, input logic [N-1:0] g, input logic v,
                           input logic [1:0] ix, input int own);
    logic [N-1:0] eg;
    logic [1:0]   ei;
    eg = '0;
    ei = '0;
    if (own >= 0) begin
      eg[own] = 1'b1;
      ei = 2'(own);
    end
    checks += 3;
    assert (g === eg) else begin
      errors++; $error("FAIL %s_grant got=%b exp=%b", tag, g, eg);
    end
    assert (v === (own >= 0)) else begin
      errors++; $error("FAIL %s_valid got=%b exp=%b", tag, v, (own >= 0));
    end
    assert (ix === ei) else begin
      errors++; $error("FAIL %s_idx got=%0d exp=%0d", tag, ix, ei);
    end
  endtask

  task automatic expect_grant(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r_n, input logic [N-1:0] r);
    @(negedge clk);
    rst_n = r_n;
    req   = r;
    @(posedge clk);
    model_step(4, own4, held4, ptr4);
    model_step(1, own1, held1, ptr1);
    #1;
    check_dut("b4", g4, v4, i4, own4);
    check_dut("b1", g1, v1, i1, own1);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;

    // Reset with all requests active, then the pointer-0 grant and full rotation.
    cyc(1'b0, 4'b1111);
    cyc(1'b0, 4'b1111);
    expect_grant("rst_grant", g4, 4'b0000);
    cyc(1'b1, 4'b1111);
    expect_grant("first_grant", g4, 4'b0001);
    for (int c = 0; c < 15; c++) cyc(1'b1, 4'b1111);
    expect_grant("rot_last", g4, 4'b1000);
    cyc(1'b1, 4'b1111);
    expect_grant("ptr_wrap", g4, 4'b0001);

    // Single requester stays granted across pre-emptions.
    for (int c = 0; c < 10; c++) begin
      cyc(1'b1, 4'b1000);
      expect_grant("single", g4, 4'b1000);
    end

    // Early release hands over without a bubble, then idle.
    cyc(1'b1, 4'b0000);
    cyc(1'b1, 4'b0010);
    expect_grant("owner1", g4, 4'b0010);
    cyc(1'b1, 4'b0110);
    cyc(1'b1, 4'b0100);
    expect_grant("early_rel", g4, 4'b0100);
    cyc(1'b1, 4'b0000);
    expect_grant("to_idle", g4, 4'b0000);

    // Reset mid-burst clears the pointer.
    cyc(1'b1, 4'b0100);
    cyc(1'b1, 4'b0100);
    cyc(1'b0, 4'b0100);
    expect_grant("mid_rst", g4, 4'b0000);
    cyc(1'b1, 4'b1100);
    expect_grant("post_rst", g4, 4'b0100);

    // Plain round robin on the MAX_BURST=1 instance.
    cyc(1'b0, 4'b0000);
    cyc(1'b1, 4'b1011);
    expect_grant("rr1_a", g1, 4'b0001);
    cyc(1'b1, 4'b1011);
    expect_grant("rr1_b", g1, 4'b0010);
    cyc(1'b1, 4'b1011);
    expect_grant("rr1_c", g1, 4'b1000);
    cyc(1'b1, 4'b1011);
    expect_grant("rr1_d", g1, 4'b0001);

`ifdef ARB_LOCK_EN
    cyc(1'b0, 4'b0000);
    lock = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      cyc(1'b1, 4'b0011);
      expect_grant("lock_hold", g4, 4'b0001);
    end
    lock = 4'b0000;
    cyc(1'b1, 4'b0011);
    expect_grant("lock_drop", g4, 4'b0010);
`endif

    // Random traffic with occasional reset.
    for (int c = 0; c < 400; c++) begin
`ifdef ARB_LOCK_EN
      lock = 4'($urandom);
`endif
      cyc(($urandom_range(0, 39) != 0), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rr_arbiter_burst
`default_nettype wire
